// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the synchronous ROM address and hands {instr, pc} to decode
// through an out entry plus one skid entry. Optional perf counters under IF_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC   = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_address,
    input  logic [31:0] instruction_code,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
`ifdef IF_PERF_CNT_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;

    logic                  out_valid;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  skid_valid;
    logic [31:0]           skid_instr;
    logic [ADDR_WIDTH-1:0] skid_pc;

    logic                  out_valid_d;
    logic [31:0]           out_instr_d;
    logic [ADDR_WIDTH-1:0] out_pc_d;
    logic                  skid_valid_d;
    logic [31:0]           skid_instr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_d;

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  drain;
    logic [1:0]            held;
    logic                  issue;
    logic                  resp;

    wire unused_redirect_hi = ^redirect_pc[31:ADDR_WIDTH];

    assign fetch_addr = redirect_valid ? redirect_pc[ADDR_WIDTH-1:0] : pc_q;
    assign pc_address = {{(32-ADDR_WIDTH){1'b0}}, fetch_addr};

    assign drain = out_valid & id_ready;
    assign held  = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, req_valid_q} - {1'b0, drain};
    assign issue = redirect_valid | (held <= 2'd1);
    // A redirect makes the in-flight response stale, so it is never captured.
    assign resp  = req_valid_q & ~redirect_valid;

    assign if_valid = out_valid;
    assign if_instr = out_instr;
    assign if_pc    = {{(32-ADDR_WIDTH){1'b0}}, out_pc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_ADDR;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else if (issue) begin
            pc_q        <= fetch_addr + 1'b1;
            req_valid_q <= 1'b1;
            req_pc_q    <= fetch_addr;
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid;
        out_instr_d  = out_instr;
        out_pc_d     = out_pc;
        skid_valid_d = skid_valid;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;
        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (resp) begin
            if ((!out_valid || drain) && !skid_valid) begin
                out_valid_d = 1'b1;
                out_instr_d = instruction_code;
                out_pc_d    = req_pc_q;
            end else if (drain) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr;
                out_pc_d     = skid_pc;
                skid_valid_d = 1'b1;
                skid_instr_d = instruction_code;
                skid_pc_d    = req_pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = instruction_code;
                skid_pc_d    = req_pc_q;
            end
        end else if (drain) begin
            if (skid_valid) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr;
                out_pc_d     = skid_pc;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            out_valid  <= out_valid_d;
            out_instr  <= out_instr_d;
            out_pc     <= out_pc_d;
            skid_valid <= skid_valid_d;
            skid_instr <= skid_instr_d;
            skid_pc    <= skid_pc_d;
        end
    end

    // The credit rule keeps at most two words held, so a response never finds both entries busy.
    always_ff @(posedge clk) begin
        if (rst && resp) begin
            assert (!(out_valid && !drain && skid_valid))
                else $error("instr_fetch_unit: skid overflow at pc %0h", req_pc_q);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [1:0] flushed;

    assign flushed = {1'b0, out_valid & ~drain} + {1'b0, skid_valid} + {1'b0, req_valid_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (drain) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                flush_cnt <= flush_cnt + {30'd0, flushed};
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle ROM model where ROM[a] = a + 0x100.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_address;
    logic [31:0] instruction_code = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    instr_fetch_unit #(.ADDR_WIDTH(10), .RESET_PC(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_address       (pc_address),
        .instruction_code (instruction_code),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .id_ready         (id_ready),
        .redirect_valid   (redirect_valid),
`ifdef IF_PERF_CNT_EN
        .redirect_pc      (redirect_pc),
        .fetch_cnt        (fetch_cnt),
        .flush_cnt        (flush_cnt)
`else
        .redirect_pc      (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) instruction_code <= 32'h100 + pc_address;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, " pc"}, if_pc, pc);
        check({tag, " instr"}, if_instr, 32'h100 + pc);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic        prev_stall;
        int          handshakes;
`ifdef IF_PERF_CNT_EN
        logic [31:0] cnt_snap;
`endif

        // reset state
        step();
        step();
        check("rst valid", {31'd0, if_valid}, 32'd0);
        check("rst instr", if_instr, 32'd0);
        check("rst pc", if_pc, 32'd0);
        check("rst addr", pc_address, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("rst fetch_cnt", fetch_cnt, 32'd0);
        check("rst flush_cnt", flush_cnt, 32'd0);
`endif

        // release: first word two edges later, then one per cycle
        id_ready = 1'b1;
        rst = 1'b1;
        step();
        check("startup gap", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            step();
            expect_word("stream", i);
        end

        // stall on pc 4 for five cycles
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_word("stall hold", 32'd4);
        end
        id_ready = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            step();
            expect_word("stall release", i);
        end

        // build out+skid occupancy at pc 8, then redirect to 0x20
        id_ready = 1'b0;
        step();
        step();
        expect_word("pre-redirect", 32'd8);
`ifdef IF_PERF_CNT_EN
        cnt_snap = flush_cnt;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        #1;
        check("redirect addr", pc_address, 32'h20);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check("redirect bubble", {31'd0, if_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("flush_cnt delta", flush_cnt - cnt_snap, 32'd2);
`endif
        step();
        expect_word("redirect tgt", 32'h20);
        step();
        expect_word("redirect next", 32'h21);

        // redirect to the last word, upper target bits ignored, stream wraps
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_F3FF;
        #1;
        check("wrap addr", pc_address, 32'h3FF);
        step();
        redirect_valid = 1'b0;
        check("wrap bubble", {31'd0, if_valid}, 32'd0);
        step();
        expect_word("wrap last", 32'h3FF);
        step();
        expect_word("wrap zero", 32'h000);
        step();
        expect_word("wrap one", 32'h001);

        // random back-pressure: strictly sequential delivery, stable while stalled
        exp_pc     = 32'd2;
        prev_stall = 1'b0;
        prev_pc    = '0;
        handshakes = 0;
        step();
`ifdef IF_PERF_CNT_EN
        cnt_snap = fetch_cnt;
`endif
        for (int i = 0; i < 2000; i++) begin
            id_ready = ($urandom_range(0, 1) == 1);
            if (prev_stall) begin
                check("rand hold valid", {31'd0, if_valid}, 32'd1);
                check("rand hold pc", if_pc, prev_pc);
            end
            if (if_valid && id_ready) begin
                check("rand pc", if_pc, exp_pc);
                check("rand instr", if_instr, 32'h100 + exp_pc);
                exp_pc = (exp_pc + 32'd1) & 32'h3FF;
                handshakes++;
            end
            prev_stall = if_valid & ~id_ready;
            prev_pc    = if_pc;
            step();
        end
        check("rand progress", {31'd0, handshakes > 600}, 32'd1);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt delta", fetch_cnt - cnt_snap, handshakes);
`endif

        // asynchronous reset mid-stream
        id_ready = 1'b1;
        step();
        step();
        check("pre-reset valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("async valid", {31'd0, if_valid}, 32'd0);
        check("async pc", if_pc, 32'd0);
        check("async instr", if_instr, 32'd0);
        check("async addr", pc_address, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("async fetch_cnt", fetch_cnt, 32'd0);
`endif
        step();
        rst = 1'b1;
        step();
        check("restart gap", {31'd0, if_valid}, 32'd0);
        step();
        expect_word("restart", 32'd0);
        step();
        expect_word("restart next", 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
